rx_controller: RTL
==================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the data bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per bit; legal values are even and at least 4.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 serial_in  input  1  raw asynchronous UART line, idle high.
REQ-006 SAMPLING_DONE  input  1  one-cycle pulse from the datapath sample counter.
REQ-007 RX_CMP  input  1  datapath bit-counter complete flag.
REQ-008 count_enb  output  1  sample-counter enable.
REQ-009 shift_en  output  1  SIPO shift strobe.
REQ-010 bit_enb  output  1  bit-counter increment strobe.
REQ-011 ld_data  output  1  output-register load strobe.
REQ-012 rx_valid  output  1  one-cycle pulse: frame received, RX_DATA updated.
REQ-013 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 sync_err  output  1  one-cycle pulse: DATAWIDTH bits shifted without RX_CMP.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Datapath contract: SAMPLING_DONE pulses after count_enb has been high for CLKS_PER_BIT consecutive cycles, then every CLKS_PER_BIT cycles; the sample counter returns to 0 whenever count_enb is low; RX_CMP is high while the bit counter holds DATAWIDTH strobes.
REQ-017 serial_in SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value (rx_s).
REQ-018 All outputs SHALL be registered.
REQ-019 States: IDLE, START, DATA, CHECK, STOP, LOAD, BREAK.
REQ-020 IDLE: count_enb=0. A 1->0 transition of rx_s moves to START and clears the internal half-bit counter.
REQ-021 START: count to CLKS_PER_BIT/2 cycles. At terminal count, rx_s=0 moves to DATA with count_enb=1 from the next cycle. rx_s=1 is a false start: return to IDLE with no strobes.
REQ-022 DATA: count_enb=1. On each SAMPLING_DONE, assert shift_en and bit_enb together for exactly one cycle on the following cycle, increment internal bit_idx, then enter CHECK.
REQ-023 CHECK: sample RX_CMP two cycles after the bit_enb strobe.
  - RX_CMP=1 moves to STOP.
  - RX_CMP=0 with bit_idx<DATAWIDTH returns to DATA.
  - RX_CMP=0 with bit_idx=DATAWIDTH pulses sync_err and moves to BREAK.
  - count_enb stays 1 throughout CHECK.
REQ-024 STOP: count_enb=1. On SAMPLING_DONE:
  - rx_s=1 moves to LOAD.
  - rx_s=0 pulses frame_err, asserts no ld_data, and moves to BREAK.
REQ-025 LOAD: one cycle. ld_data=1 and rx_valid=1 in the same cycle, count_enb=0, then IDLE.
REQ-026 BREAK: count_enb=0. Stay until rx_s=1, then IDLE. A line held low never produces a new START.
REQ-027 RX_CMP=1 seen in CHECK before bit_idx=DATAWIDTH SHALL be accepted as completion (datapath is authoritative); bit_idx clears on entering IDLE.
REQ-028 Per frame, shift_en and bit_enb SHALL pulse exactly DATAWIDTH times, never in the same cycle as ld_data.
REQ-029 A falling edge on rx_s in any state other than IDLE SHALL be ignored.
REQ-030 SAMPLING_DONE outside DATA and STOP SHALL be ignored.

Reset
REQ-031 While rst=0 at a clk edge, the state SHALL become IDLE and the synchronizer SHALL become 1.
REQ-032 While rst=0, bit_idx and the half-bit counter SHALL become 0, and every output SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no ld_data, rx_valid or error pulse; the next frame is received normally after release.

Verification
REQ-034 Frame 0xA5 (LSB first, 1 start, 1 stop, CLKS_PER_BIT=16) -> 8 shift_en/bit_enb pulses 16 cycles apart, one ld_data+rx_valid, RX_DATA=0xA5, no error pulses.
REQ-035 Line low 5 cycles then high -> returns to IDLE, busy high 8 cycles at most, zero strobes, count_enb never high.
REQ-036 Frame 0x3C with stop bit driven 0 -> frame_err pulse once, no ld_data. Line held low 100 cycles -> no new frame. Next valid frame 0x0F -> rx_valid, RX_DATA=0x0F.
REQ-037 RX_CMP forced 0 for a whole frame -> sync_err pulse after the 8th bit_enb, no ld_data, BREAK then IDLE.
REQ-038 rst=0 for one cycle after the 4th data bit -> all outputs 0 next cycle, no rx_valid. Following frame 0x81 -> RX_DATA=0x81.
REQ-039 Two back-to-back frames 0x55, 0xAA (no idle gap beyond stop bit) -> two rx_valid pulses, data in order.

Source files
------------

// File: rtl/rx_controller.sv
// -----------------------------------------------------------------------------
// rx_controller
//
// Control FSM for a UART receiver.
//
// The sample counter, bit counter, SIPO shift register and output data
// register all live in a separate datapath. This block sequences that
// datapath: it finds the start bit, strobes one shift per data bit, checks
// the stop bit, and flags framing and synchronisation errors.
//
// Parameters
//   DATAWIDTH     data bits per frame (default 8)
//   CLKS_PER_BIT  clk cycles per bit; must be even and >= 4 (default 16)
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-low reset
//   serial_in      in   raw asynchronous line, idle high
//   SAMPLING_DONE  in   one-cycle pulse from the datapath sample counter
//   RX_CMP         in   datapath bit counter holds DATAWIDTH strobes
//   count_enb      out  sample-counter enable
//   shift_en       out  SIPO shift strobe
//   bit_enb        out  bit-counter increment strobe
//   ld_data        out  output-register load strobe
//   rx_valid       out  one-cycle pulse: frame received
//   frame_err      out  one-cycle pulse: stop bit sampled low
//   sync_err       out  one-cycle pulse: DATAWIDTH shifts without RX_CMP
//   busy           out  high in every state except IDLE
//
// All outputs are registered. They are computed from the next state, so each
// output register changes on the same edge as the state register and always
// agrees with it.
// -----------------------------------------------------------------------------
module rx_controller #(
    parameter int DATAWIDTH    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic SAMPLING_DONE,
    input  logic RX_CMP,
    output logic count_enb,
    output logic shift_en,
    output logic bit_enb,
    output logic ld_data,
    output logic rx_valid,
    output logic frame_err,
    output logic sync_err,
    output logic busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int HALF_W   = (HALF_BIT > 2) ? $clog2(HALF_BIT) : 1;
    localparam int IDX_W    = $clog2(DATAWIDTH + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(DATAWIDTH);

    // RX_CMP is sampled two cycles after the bit_enb strobe. The bit counter
    // updates at the end of the strobe cycle, so the flag is settled one
    // cycle later. The extra cycle gives margin for a registered flag.
    localparam logic [1:0] CHK_LAST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_STOP  = 3'd4,
        ST_LOAD  = 3'd5,
        ST_BREAK = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [1:0]         sync_r;
    logic               rx_s;
    logic               rx_prev_r;
    logic               fall_s;
    logic [HALF_W-1:0]  half_cnt_r;
    logic [HALF_W-1:0]  half_cnt_nx_s;
    logic [1:0]         chk_cnt_r;
    logic [1:0]         chk_cnt_nx_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   bit_idx_nx_s;
    logic               count_enb_nx_s;
    logic               shift_nx_s;
    logic               load_nx_s;
    logic               frame_err_nx_s;
    logic               sync_err_nx_s;
    logic               busy_nx_s;

    // The synchronised line is the last stage of the synchronizer.
    assign rx_s = sync_r[1];

    // A 1->0 step of the synchronised line. This only matters in IDLE.
    assign fall_s = rx_prev_r & ~rx_s;

    // Two-flop synchronizer and previous-value tracker for edge detection.
    // Both reset to idle-high, so a line that is low at reset release shows
    // one falling edge. That matches a genuine start bit arriving then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], serial_in};
            rx_prev_r <= rx_s;
        end
    end

    // Next-state logic plus next values of the counters and output strobes.
    always_comb begin
        state_nx_s     = state_r;
        half_cnt_nx_s  = half_cnt_r;
        chk_cnt_nx_s   = chk_cnt_r;
        bit_idx_nx_s   = bit_idx_r;
        shift_nx_s     = 1'b0;
        load_nx_s      = 1'b0;
        frame_err_nx_s = 1'b0;
        sync_err_nx_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nx_s    = ST_START;
                    half_cnt_nx_s = '0;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end

            // Wait half a bit, then confirm the start bit is still low.
            // A line that has returned high is treated as noise.
            ST_START: begin
                if (half_cnt_r == HALF_LAST) begin
                    if (!rx_s) begin
                        state_nx_s = ST_DATA;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    half_cnt_nx_s = half_cnt_r + HALF_W'(1);
                end
            end

            ST_DATA: begin
                if (SAMPLING_DONE) begin
                    shift_nx_s   = 1'b1;
                    bit_idx_nx_s = bit_idx_r + IDX_W'(1);
                    chk_cnt_nx_s = 2'd0;
                    state_nx_s   = ST_CHECK;
                end else begin
                    state_nx_s   = ST_DATA;
                end
            end

            // The datapath bit counter decides completion. bit_idx is only a
            // backstop that catches a counter that never reports completion.
            ST_CHECK: begin
                if (chk_cnt_r == CHK_LAST) begin
                    if (RX_CMP) begin
                        state_nx_s = ST_STOP;
                    end else if (bit_idx_r < IDX_FULL) begin
                        state_nx_s = ST_DATA;
                    end else begin
                        sync_err_nx_s = 1'b1;
                        state_nx_s    = ST_BREAK;
                    end
                end else begin
                    chk_cnt_nx_s = chk_cnt_r + 2'd1;
                end
            end

            ST_STOP: begin
                if (SAMPLING_DONE) begin
                    if (rx_s) begin
                        load_nx_s  = 1'b1;
                        state_nx_s = ST_LOAD;
                    end else begin
                        frame_err_nx_s = 1'b1;
                        state_nx_s     = ST_BREAK;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end

            ST_LOAD: begin
                state_nx_s = ST_IDLE;
            end

            // Wait for the line to go idle so a long low period (a break or
            // a misaligned frame) cannot start a new frame.
            ST_BREAK: begin
                if (rx_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BREAK;
                end
            end

            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        if (state_nx_s == ST_IDLE) begin
            bit_idx_nx_s = '0;
        end else begin
            bit_idx_nx_s = bit_idx_nx_s;
        end

        // The sample counter runs from the first data bit through the stop
        // bit without a gap, so it stays in phase with the bit centres.
        case (state_nx_s)
            ST_DATA, ST_CHECK, ST_STOP: count_enb_nx_s = 1'b1;
            default:                    count_enb_nx_s = 1'b0;
        endcase

        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            half_cnt_r <= '0;
            chk_cnt_r  <= 2'd0;
            bit_idx_r  <= '0;
            count_enb  <= 1'b0;
            shift_en   <= 1'b0;
            bit_enb    <= 1'b0;
            ld_data    <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            half_cnt_r <= half_cnt_nx_s;
            chk_cnt_r  <= chk_cnt_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            count_enb  <= count_enb_nx_s;
            shift_en   <= shift_nx_s;
            bit_enb    <= shift_nx_s;
            ld_data    <= load_nx_s;
            rx_valid   <= load_nx_s;
            frame_err  <= frame_err_nx_s;
            sync_err   <= sync_err_nx_s;
            busy       <= busy_nx_s;
        end
    end

endmodule
